// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, stall request
// levels and the pipeline stall-vector bit positions it listens to.
package bus_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_BUSY_I = 3'd1,
      S_BUSY_D = 3'd2,
      S_HOLD_I = 3'd3,
      S_HOLD_D = 3'd4,
      S_DRAIN  = 3'd5
   } state_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Bit positions in the 6-bit pipeline stall vector.
   localparam int STALL_IF  = 1;
   localparam int STALL_MEM = 4;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates the single req/ack memory bus between instruction fetch and the
// MEM-stage data port. Data wins ties. Completed reads are parked in hold
// registers while the owning stage is frozen; a flushed access is never
// aborted on the bus but is drained and its data dropped.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [3:0]        d_sel,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stallreq_if,
   output logic              stallreq_mem,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [3:0]        m_sel,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata
);

   state_t              r_state,   w_state_nxt;
   logic                r_m_req,   w_m_req_nxt;
   logic                r_m_we,    w_m_we_nxt;
   logic [ADDR_W-1:0]   r_m_addr,  w_m_addr_nxt;
   logic [3:0]          r_m_sel,   w_m_sel_nxt;
   logic [DATA_W-1:0]   r_m_wdata, w_m_wdata_nxt;
   logic [DATA_W-1:0]   r_hold_i,  w_hold_i_nxt;
   logic [DATA_W-1:0]   r_hold_d,  w_hold_d_nxt;

   logic w_ack_i;
   logic w_ack_d;
   logic w_unused_stall;

   assign w_ack_i        = (r_state == S_BUSY_I) && m_ack;
   assign w_ack_d        = (r_state == S_BUSY_D) && m_ack;
   assign w_unused_stall = ^{stall[5], stall[3:2], stall[0]};

   // Next-state and next bus/hold register values; everything holds by default.
   always_comb begin
      w_state_nxt   = r_state;
      w_m_req_nxt   = r_m_req;
      w_m_we_nxt    = r_m_we;
      w_m_addr_nxt  = r_m_addr;
      w_m_sel_nxt   = r_m_sel;
      w_m_wdata_nxt = r_m_wdata;
      w_hold_i_nxt  = r_hold_i;
      w_hold_d_nxt  = r_hold_d;
      case (r_state)
         S_IDLE: begin
            if (!flush) begin
               if (d_req) begin
                  w_m_req_nxt   = 1'b1;
                  w_m_we_nxt    = d_we;
                  w_m_addr_nxt  = d_addr;
                  w_m_sel_nxt   = d_sel;
                  w_m_wdata_nxt = d_wdata;
                  w_state_nxt   = S_BUSY_D;
               end else if (i_req) begin
                  w_m_req_nxt  = 1'b1;
                  w_m_we_nxt   = 1'b0;
                  w_m_addr_nxt = i_addr;
                  w_m_sel_nxt  = 4'hF;
                  w_state_nxt  = S_BUSY_I;
               end
            end
         end
         S_BUSY_I, S_BUSY_D: begin
            if (m_ack) begin
               w_m_req_nxt = 1'b0;
               w_m_we_nxt  = 1'b0;
               if (flush) begin
                  w_state_nxt = S_IDLE;
               end else if (r_state == S_BUSY_I) begin
                  w_hold_i_nxt = m_rdata;
                  w_state_nxt  = stall[STALL_IF] ? S_HOLD_I : S_IDLE;
               end else begin
                  w_hold_d_nxt = m_rdata;
                  w_state_nxt  = stall[STALL_MEM] ? S_HOLD_D : S_IDLE;
               end
            end else if (flush) begin
               // The slave is already committed; let it finish and drop the result.
               w_state_nxt = S_DRAIN;
            end
         end
         S_HOLD_I: begin
            if (!stall[STALL_IF] || flush) w_state_nxt = S_IDLE;
         end
         S_HOLD_D: begin
            if (!stall[STALL_MEM] || flush) w_state_nxt = S_IDLE;
         end
         S_DRAIN: begin
            if (m_ack) begin
               w_m_req_nxt = 1'b0;
               w_m_we_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, bus and hold registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_m_req   <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_sel   <= '0;
         r_m_wdata <= '0;
         r_hold_i  <= '0;
         r_hold_d  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_m_req   <= w_m_req_nxt;
         r_m_we    <= w_m_we_nxt;
         r_m_addr  <= w_m_addr_nxt;
         r_m_sel   <= w_m_sel_nxt;
         r_m_wdata <= w_m_wdata_nxt;
         r_hold_i  <= w_hold_i_nxt;
         r_hold_d  <= w_hold_d_nxt;
      end
   end

   assign m_req   = r_m_req;
   assign m_we    = r_m_we;
   assign m_addr  = r_m_addr;
   assign m_sel   = r_m_sel;
   assign m_wdata = r_m_wdata;

   // Read data: live bus data on an unflushed completion, parked data while held.
   always_comb begin
      i_rdata = '0;
      d_rdata = '0;
      if (w_ack_i && !flush)        i_rdata = m_rdata;
      else if (r_state == S_HOLD_I) i_rdata = r_hold_i;
      if (w_ack_d && !flush)        d_rdata = m_rdata;
      else if (r_state == S_HOLD_D) d_rdata = r_hold_d;
   end

   // A post-flush fetch keeps waiting through DRAIN; the data port does not.
   assign stallreq_if  = (i_req && !w_ack_i && (r_state != S_HOLD_I)) ? STOP : NO_STOP;
   assign stallreq_mem = (d_req && !w_ack_d && (r_state != S_HOLD_D) &&
                          (r_state != S_DRAIN)) ? STOP : NO_STOP;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a word memory behind a variable-latency slave, a
// reference memory updated in program order, and a monitor that checks every
// bus transaction and every read completion against queued expectations.
module tb_bus_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_sel;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        stallreq_if;
   logic        stallreq_mem;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [3:0]  m_sel;
   logic [31:0] m_wdata;
   logic        m_ack;
   logic [31:0] m_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   bus_t        exp_bus[$];
   logic [31:0] exp_i[$];
   logic [31:0] exp_d[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] slv_mem[logic [31:0]];

   int slave_lat = 0;
   int force_cnt = 0;

   bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel),
      .d_wdata(d_wdata), .d_rdata(d_rdata),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel),
      .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- memory reference ----------------
   function automatic logic [31:0] mem_dflt(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, wd, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] rd_ref(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : mem_dflt(a);
   endfunction

   function automatic logic [31:0] rd_slv(input logic [31:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : mem_dflt(a);
   endfunction

   // ---------------- check helpers ----------------
   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chkbus(input string nm, input bus_t act, input bus_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got we=%b addr=%h sel=%h wd=%h expected we=%b addr=%h sel=%h wd=%h",
                  nm, act.we, act.addr, act.sel, act.wdata, exp.we, exp.addr, exp.sel, exp.wdata);
      end
   endtask

   task automatic fail_now(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event", nm);
   endtask

   // ---------------- expectation producers ----------------
   task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] sel,
                           input logic [31:0] wd);
      bus_t b;
      b.we = we; b.addr = a; b.sel = sel; b.wdata = we ? wd : 32'h0;
      exp_bus.push_back(b);
   endtask

   task automatic push_fetch(input logic [31:0] a);
      push_bus(1'b0, a, 4'hF, 32'h0);
      exp_i.push_back(rd_ref(a));
   endtask

   task automatic push_data(input logic we, input logic [31:0] a, input logic [3:0] sel,
                            input logic [31:0] wd);
      push_bus(we, a, sel, wd);
      if (we) ref_mem[a] = merge(rd_ref(a), wd, sel);
      else    exp_d.push_back(rd_ref(a));
   endtask

   task automatic set_mem(input logic [31:0] a, input logic [31:0] v);
      ref_mem[a] = v;
      slv_mem[a] = v;
   endtask

   // ---------------- slave model ----------------
   initial begin : slave
      int s_cnt, s_lat, f_seen;
      m_ack = 1'b0; m_rdata = 32'h0; s_cnt = -1; s_lat = 0; f_seen = 0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            m_ack = 1'b0; s_cnt = -1;
         end else if (force_cnt != f_seen) begin
            f_seen = force_cnt; m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
         end else if (m_ack) begin
            m_ack = 1'b0; s_cnt = -1; m_rdata = $urandom;
         end else if (m_req) begin
            if (s_cnt < 0) begin s_cnt = 0; s_lat = slave_lat; end
            if (s_lat >= 0) begin
               if (s_cnt == s_lat) begin
                  m_ack = 1'b1;
                  if (m_we) begin
                     slv_mem[m_addr] = merge(rd_slv(m_addr), m_wdata, m_sel);
                     m_rdata = $urandom;
                  end else m_rdata = rd_slv(m_addr);
               end else s_cnt++;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic prev_mreq, prev_is, prev_ds;
      bus_t cur, prev_b, eb;
      prev_mreq = 1'b0; prev_is = 1'b0; prev_ds = 1'b0; prev_b = '0;
      forever begin
         @(negedge clk);
         cur.we = m_we; cur.addr = m_addr; cur.sel = m_sel;
         cur.wdata = m_we ? m_wdata : 32'h0;
         if (rst) begin
            prev_mreq = 1'b0; prev_is = 1'b0; prev_ds = 1'b0;
         end else begin
            if (m_req && !prev_mreq) begin
               if (exp_bus.size() == 0) fail_now("bus_unexpected");
               else begin
                  eb = exp_bus.pop_front();
                  chkbus("bus_txn", cur, eb);
               end
            end else if (m_req && prev_mreq) begin
               chkbus("bus_stable", cur, prev_b);
            end
            if (i_req && !stallreq_if && prev_is && !flush) begin
               if (exp_i.size() == 0) fail_now("i_done_unexpected");
               else chk32("i_rdata", i_rdata, exp_i.pop_front());
            end
            if (d_req && !d_we && !stallreq_mem && prev_ds && !flush) begin
               if (exp_d.size() == 0) fail_now("d_done_unexpected");
               else chk32("d_rdata", d_rdata, exp_d.pop_front());
            end
            prev_mreq = m_req;
            prev_is   = i_req && stallreq_if;
            prev_ds   = d_req && stallreq_mem;
         end
         prev_b = cur;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic cyc();
      @(posedge clk); #2;
   endtask

   task automatic wait_if_done();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!stallreq_if) begin
            cyc();
            i_req = 1'b0;
            return;
         end
      end
      fail_now("wait_if_timeout");
      i_req = 1'b0;
   endtask

   task automatic drive_access(input bit di, input bit dd, input bit dwe,
                               input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] wd, input logic [3:0] sel);
      bit idone, ddone;
      int budget;
      if (dd) push_data(dwe, da, sel, wd);
      if (di) push_fetch(ia);
      cyc();
      i_req = di; i_addr = ia;
      d_req = dd; d_we = dwe; d_addr = da; d_sel = sel; d_wdata = wd;
      idone = !di; ddone = !dd; budget = 60;
      while (!(idone && ddone) && budget > 0) begin
         @(negedge clk);
         if (!idone && !stallreq_if)  idone = 1'b1;
         if (!ddone && !stallreq_mem) ddone = 1'b1;
         cyc();
         if (idone) i_req = 1'b0;
         if (ddone) d_req = 1'b0;
         budget--;
      end
      if (!(idone && ddone)) fail_now("access_timeout");
      i_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : main
      rst = 1'b1; stall = 6'h0; flush = 1'b0;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_sel = 4'h0; d_wdata = 32'h0;
      repeat (3) cyc();
      rst = 1'b0;
      @(negedge clk);
      chk1("rst_m_req", m_req, 1'b0);
      chk1("rst_m_we", m_we, 1'b0);
      chk32("rst_m_addr", m_addr, 32'h0);
      chk32("rst_m_sel", {28'h0, m_sel}, 32'h0);
      chk32("rst_m_wdata", m_wdata, 32'h0);
      chk32("rst_i_rdata", i_rdata, 32'h0);
      chk32("rst_d_rdata", d_rdata, 32'h0);

      // fetch, zero-wait slave
      set_mem(32'h100, 32'h3C010000);
      slave_lat = 0;
      push_fetch(32'h100);
      cyc(); i_req = 1'b1; i_addr = 32'h100;
      @(negedge clk);
      chk1("t1_stall_req", stallreq_if, 1'b1);
      chk1("t1_mreq_idle", m_req, 1'b0);
      cyc();
      @(negedge clk);
      chk1("t1_mreq", m_req, 1'b1);
      chk1("t1_unstall", stallreq_if, 1'b0);
      chk32("t1_rdata", i_rdata, 32'h3C010000);
      cyc(); i_req = 1'b0;
      @(negedge clk);
      chk1("t1_mreq_drop", m_req, 1'b0);
      chk32("t1_rdata_idle", i_rdata, 32'h0);

      // simultaneous fetch and load: data first, fetch after an IDLE cycle
      set_mem(32'h2000, 32'hDEADBEEF);
      slave_lat = 1;
      push_data(1'b0, 32'h2000, 4'hF, 32'h0);
      push_fetch(32'h104);
      cyc();
      i_req = 1'b1; i_addr = 32'h104;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_sel = 4'hF;
      @(negedge clk);
      chk1("t2_smem0", stallreq_mem, 1'b1);
      chk1("t2_sif0", stallreq_if, 1'b1);
      cyc(); @(negedge clk);
      chk32("t2_addr_d", m_addr, 32'h2000);
      chk1("t2_smem1", stallreq_mem, 1'b1);
      cyc(); @(negedge clk);
      chk1("t2_smem_ack", stallreq_mem, 1'b0);
      chk1("t2_sif_ack", stallreq_if, 1'b1);
      chk32("t2_drdata", d_rdata, 32'hDEADBEEF);
      cyc(); d_req = 1'b0;
      @(negedge clk);
      chk1("t2_idle_gap", m_req, 1'b0);
      chk1("t2_sif_gap", stallreq_if, 1'b1);
      cyc(); @(negedge clk);
      chk1("t2_fetch_issued", m_req, 1'b1);
      chk32("t2_addr_i", m_addr, 32'h104);
      wait_if_done();

      // store completing while MEM is stalled
      slave_lat = 0;
      stall[4] = 1'b1;
      push_data(1'b1, 32'h3000, 4'b0011, 32'h1234);
      cyc();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_sel = 4'b0011; d_wdata = 32'h1234;
      @(negedge clk);
      chk1("t3_smem0", stallreq_mem, 1'b1);
      cyc(); @(negedge clk);
      chk1("t3_m_we", m_we, 1'b1);
      chk32("t3_m_sel", {28'h0, m_sel}, 32'h3);
      chk32("t3_m_wdata", m_wdata, 32'h1234);
      chk1("t3_smem_ack", stallreq_mem, 1'b0);
      cyc(); @(negedge clk);
      chk1("t3_hold_smem", stallreq_mem, 1'b0);
      chk1("t3_hold_mreq", m_req, 1'b0);
      chk1("t3_hold_mwe", m_we, 1'b0);
      cyc(); @(negedge clk);
      chk1("t3_hold2_smem", stallreq_mem, 1'b0);
      cyc(); stall[4] = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk1("t3_release_mreq", m_req, 1'b0);
      drive_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h3000, 32'h0, 4'hF);

      // flush in the middle of a fetch: drain, discard, refetch
      set_mem(32'h140, 32'hFFFFFFFF);
      slave_lat = 4;
      push_bus(1'b0, 32'h140, 4'hF, 32'h0);
      cyc(); i_req = 1'b1; i_addr = 32'h140;
      cyc(); flush = 1'b1; i_addr = 32'h180; slave_lat = 0;
      push_fetch(32'h180);
      @(negedge clk);
      chk1("t4_mreq", m_req, 1'b1);
      chk1("t4_sif_flush", stallreq_if, 1'b1);
      cyc(); flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk32("t4_drain_rdata", i_rdata, 32'h0);
         chk1("t4_drain_sif", stallreq_if, 1'b1);
         chk1("t4_drain_mreq", m_req, 1'b1);
         cyc();
      end
      @(negedge clk);
      chk1("t4_after_drain_mreq", m_req, 1'b0);
      chk1("t4_after_drain_sif", stallreq_if, 1'b1);
      wait_if_done();

      // flush coincident with ack while IF is stalled: no HOLD
      slave_lat = 1;
      stall[1] = 1'b1;
      push_bus(1'b0, 32'h150, 4'hF, 32'h0);
      cyc(); i_req = 1'b1; i_addr = 32'h150;
      cyc(); cyc(); flush = 1'b1;
      cyc(); flush = 1'b0; stall[1] = 1'b0; i_addr = 32'h154;
      push_fetch(32'h154);
      @(negedge clk);
      chk1("t5_no_hold_sif", stallreq_if, 1'b1);
      chk1("t5_idle_mreq", m_req, 1'b0);
      wait_if_done();

      // reset while a load is outstanding; late ack ignored
      slave_lat = -1;
      push_bus(1'b0, 32'h2000, 4'hF, 32'h0);
      cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_sel = 4'hF;
      cyc(); @(negedge clk);
      chk1("t6_busy_mreq", m_req, 1'b1);
      cyc(); rst = 1'b1; d_req = 1'b0;
      cyc(); rst = 1'b0;
      @(negedge clk);
      chk1("t6_rst_mreq", m_req, 1'b0);
      chk32("t6_rst_maddr", m_addr, 32'h0);
      chk1("t6_rst_smem", stallreq_mem, 1'b0);
      chk32("t6_rst_drdata", d_rdata, 32'h0);
      cyc(); force_cnt++;
      cyc(); @(negedge clk);
      chk32("t6_late_ack_drdata", d_rdata, 32'h0);
      chk32("t6_late_ack_irdata", i_rdata, 32'h0);
      cyc(); @(negedge clk);
      chk1("t6_late_ack_mreq", m_req, 1'b0);
      slave_lat = 0;
      drive_access(1'b1, 1'b0, 1'b0, 32'h1C0, 32'h0, 32'h0, 4'hF);

      // randomized traffic against the reference memory
      for (int n = 0; n < 150; n++) begin
         int op;
         bit di, dd, dwe;
         op  = $urandom_range(0, 3);
         di  = (op == 0) || (op == 3);
         dd  = (op != 0);
         dwe = (op == 2) || ((op == 3) && ($urandom_range(0, 1) == 1));
         slave_lat = $urandom_range(0, 3);
         drive_access(di, dd, dwe,
                      32'h4000 + 32'($urandom_range(0, 15)) * 4,
                      32'h4000 + 32'($urandom_range(0, 15)) * 4,
                      $urandom, 4'($urandom_range(1, 15)));
      end

      repeat (4) cyc();
      chk32("q_bus_empty", 32'(exp_bus.size()), 32'h0);
      chk32("q_i_empty", 32'(exp_i.size()), 32'h0);
      chk32("q_d_empty", 32'(exp_d.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
